inst_fetch_unit: RTL and testbench

Instruction fetch unit for the MIPS core: the producer end of the opcode interface that feeds the main control decoder, and the consumer of its Jump/Link/Branch results. It owns the program counter, reads instruction words from instruction memory over a req/ack handshake, and presents each word with its PC under a valid/ready handshake. On the handoff cycle it takes jump/branch redirects and produces the link address (PC+4) for jal.

---
 rtl/inst_fetch_unit_if.sv | 45 ++++
 rtl/inst_fetch_unit.sv | 112 +++++++++++
 tb/tb_inst_fetch_unit.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/inst_fetch_unit_if.sv
// inst_fetch_unit_if: bundles the instruction-memory port, the instruction
// handoff port and the control-decoder feedback of the fetch unit.
//
// Handshake rules:
//   imem:  imem_req/imem_addr are held stable until a cycle where
//          imem_req && imem_ack; imem_rdata is sampled only in that cycle.
//   inst:  once inst_valid rises, inst/inst_pc/pc_plus4 stay stable until a
//          cycle with inst_valid && inst_ready. That cycle is the handoff,
//          and jump_en/branch_taken/branch_imm are only looked at then.
interface inst_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;
  logic        jump_en;
  logic        branch_taken;
  logic [15:0] branch_imm;
  logic [31:0] fetch_count;
  logic        fsm_state;

  // Fetch unit side.
  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output inst_valid, inst, inst_pc, pc_plus4,
    input  inst_ready,
    input  jump_en, branch_taken, branch_imm,
    output fetch_count, fsm_state
  );

  // Memory / decoder side.
  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  inst_valid, inst, inst_pc, pc_plus4,
    output inst_ready,
    output jump_en, branch_taken, branch_imm,
    input  fetch_count, fsm_state
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: owns the PC, reads instruction words over a req/ack port,
// presents each word with its PC under valid/ready, and applies jump/branch
// redirects on the handoff cycle. No delay slots.
// Optional macro FETCH_PERF_CNT_EN: adds a handoff counter on fetch_count;
// without it fetch_count is tied to zero.
// fsm_state exposes the FSM (0 = FETCH, 1 = HOLD) for debug.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  inst_fetch_unit_if.master  bus
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_e;

  state_e      state;
  state_e      state_nxt;
  logic [31:0] pc;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic [31:0] branch_off;
  logic        req;
  logic        valid;
  logic        ack_take;
  logic        handoff;

  // A word is captured only while a request is actually outstanding.
  assign ack_take = (state == FETCH) && bus.imem_ack && !rst;
  // The handoff cycle; reset wins over a concurrent ready.
  assign handoff  = (state == HOLD) && bus.inst_ready && !rst;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // FSM next state and handshake outputs; both are masked during reset.
  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    valid     = 1'b0;
    case (state)
      FETCH: begin
        req = !rst;
        if (ack_take) state_nxt = HOLD;
      end
      HOLD: begin
        valid = !rst;
        if (handoff) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
  end

  // Link value for jal; wraps naturally at the top of the address space.
  assign pc_plus4   = inst_pc_q + 32'd4;
  assign branch_off = {{14{bus.branch_imm[15]}}, bus.branch_imm, 2'b00};

  // Redirect selection; jump outranks a taken branch.
  always_comb begin
    next_pc = pc_plus4;
    if (bus.jump_en)           next_pc = {pc_plus4[31:28], inst_q[25:0], 2'b00};
    else if (bus.branch_taken) next_pc = pc_plus4 + branch_off;
  end

  // Program counter: advances only when the held instruction is handed off.
  always_ff @(posedge clk) begin
    if (rst)          pc <= RESET_PC;
    else if (handoff) pc <= next_pc;
  end

  // Instruction holding register, loaded from memory on the accepted ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst_q    <= 32'h0;
      inst_pc_q <= 32'h0;
    end else if (ack_take) begin
      inst_q    <= bus.imem_rdata;
      inst_pc_q <= pc;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;

  // Handoff counter, wraps mod 2^32.
  always_ff @(posedge clk) begin
    if (rst)          fetch_cnt <= 32'h0;
    else if (handoff) fetch_cnt <= fetch_cnt + 32'd1;
  end

  assign bus.fetch_count = fetch_cnt;
`else
  assign bus.fetch_count = 32'h0;
`endif

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc;
  assign bus.inst_valid = valid;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.pc_plus4   = pc_plus4;
  assign bus.fsm_state  = state;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb_inst_fetch_unit: bench for inst_fetch_unit. Fetched words are pushed to
// exp_q as {pc, word} when the ack is driven and popped at the handoff.
module tb_inst_fetch_unit;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_fetch_unit_if bus ();

  inst_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          handoffs = 0;
  logic [31:0] next_addr;
  logic [63:0] exp_q[$];

  localparam logic [31:0] J_100  = 32'h0800_0040; // j 0x100
  localparam logic [31:0] BEQ_W  = 32'h1000_FFFE; // beq word
  localparam logic [31:0] NOP_W  = 32'h0000_0020;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic check_count();
    logic [31:0] exp_cnt;
`ifdef FETCH_PERF_CNT_EN
    exp_cnt = 32'(handoffs);
`else
    exp_cnt = 32'h0;
`endif
    check("fetch_count", bus.fetch_count, exp_cnt);
  endtask

  // Reset pulse of one cycle; optionally with ack and ready asserted too.
  task automatic do_reset(input bit with_ack);
    rst              = 1'b1;
    bus.imem_ack     = with_ack;
    bus.imem_rdata   = 32'hDEAD_BEEF;
    bus.inst_ready   = with_ack;
    bus.jump_en      = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_imm   = 16'h0;
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.inst_ready = 1'b0;
    exp_q.delete();
    handoffs  = 0;
    next_addr = 32'h0;
    check("rst_req", 32'(bus.imem_req), 32'h0);
    check("rst_addr", bus.imem_addr, 32'h0);
    check("rst_valid", 32'(bus.inst_valid), 32'h0);
    check("rst_inst", bus.inst, 32'h0);
    check("rst_inst_pc", bus.inst_pc, 32'h0);
    check("rst_pc_plus4", bus.pc_plus4, 32'h4);
    check("rst_state", 32'(bus.fsm_state), 32'h0);
    check_count();
    rst = 1'b0;
    #1;
    check("first_req", 32'(bus.imem_req), 32'h1);
  endtask

  // Memory side: answer the request after `waits` idle cycles.
  task automatic do_fetch(input logic [31:0] word, input int waits);
    for (int i = 0; i < waits; i++) begin
      check("wait_req", 32'(bus.imem_req), 32'h1);
      check("wait_addr", bus.imem_addr, next_addr);
      check("wait_valid", 32'(bus.inst_valid), 32'h0);
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = $urandom;
      @(negedge clk);
    end
    check("ack_req", 32'(bus.imem_req), 32'h1);
    check("ack_addr", bus.imem_addr, next_addr);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    exp_q.push_back({next_addr, word});
    @(negedge clk);
    bus.imem_ack = 1'b0;
    check("valid_after_ack", 32'(bus.inst_valid), 32'h1);
  endtask

  // Decoder side: stall with garbage controls, then hand off.
  task automatic do_handoff(input int stall, input bit jmp, input bit br, input logic [15:0] imm);
    logic [63:0] e;
    logic [31:0] pc4;
    logic [31:0] tgt;
    check("sb_nonempty", 32'(exp_q.size() != 0), 32'h1);
    if (exp_q.size() == 0) return;
    e = exp_q[0];
    for (int i = 0; i < stall; i++) begin
      bus.inst_ready   = 1'b0;
      bus.jump_en      = 1'($urandom_range(0, 1));
      bus.branch_taken = 1'($urandom_range(0, 1));
      bus.branch_imm   = 16'($urandom);
      bus.imem_ack     = 1'($urandom_range(0, 1));
      bus.imem_rdata   = $urandom;
      @(negedge clk);
      check("stall_valid", 32'(bus.inst_valid), 32'h1);
      check("stall_req", 32'(bus.imem_req), 32'h0);
      check("stall_inst", bus.inst, e[31:0]);
      check("stall_inst_pc", bus.inst_pc, e[63:32]);
    end
    e   = exp_q.pop_front();
    pc4 = e[63:32] + 32'd4;
    if (jmp)     tgt = {pc4[31:28], e[25:0], 2'b00};
    else if (br) tgt = pc4 + {{14{imm[15]}}, imm, 2'b00};
    else         tgt = pc4;
    bus.imem_ack     = 1'b0;
    bus.inst_ready   = 1'b1;
    bus.jump_en      = jmp;
    bus.branch_taken = br;
    bus.branch_imm   = imm;
    check("ho_valid", 32'(bus.inst_valid), 32'h1);
    check("ho_inst", bus.inst, e[31:0]);
    check("ho_inst_pc", bus.inst_pc, e[63:32]);
    check("ho_pc_plus4", bus.pc_plus4, pc4);
    @(negedge clk);
    bus.inst_ready   = 1'b0;
    bus.jump_en      = 1'b0;
    bus.branch_taken = 1'b0;
    handoffs++;
    next_addr = tgt;
    check("next_req", 32'(bus.imem_req), 32'h1);
    check("next_addr", bus.imem_addr, tgt);
    check("next_valid", 32'(bus.inst_valid), 32'h0);
    check_count();
  endtask

  initial begin
    rst              = 1'b1;
    bus.imem_ack     = 1'b0;
    bus.imem_rdata   = 32'h0;
    bus.inst_ready   = 1'b0;
    bus.jump_en      = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_imm   = 16'h0;
    next_addr        = 32'h0;
    repeat (2) @(negedge clk);
    do_reset(1'b0);

    // Sequential fetch with zero-wait memory: 0x0, 0x4, 0x8.
    for (int i = 0; i < 3; i++) begin
      check("seq_addr", bus.imem_addr, 32'(i * 4));
      do_fetch(NOP_W, 0);
      do_handoff(0, 1'b0, 1'b0, 16'h0);
    end
    // Delayed ack.
    do_fetch(NOP_W, 3);
    do_handoff(0, 1'b0, 1'b0, 16'h0);
    check("seq_end_addr", bus.imem_addr, 32'h10);

    // jal at 0x0.
    do_reset(1'b0);
    do_fetch(32'h0C00_0010, 0);
    check("jal_pc_plus4", bus.pc_plus4, 32'h4);
    do_handoff(0, 1'b1, 1'b0, 16'h0);
    check("jal_target", bus.imem_addr, 32'h40);

    // Branches from 0x100.
    do_reset(1'b0);
    do_fetch(J_100, 0);
    do_handoff(0, 1'b1, 1'b0, 16'h0);
    check("j_target", bus.imem_addr, 32'h100);
    do_fetch(BEQ_W, 1);
    do_handoff(0, 1'b0, 1'b1, 16'hFFFE);
    check("beq_back", bus.imem_addr, 32'hFC);
    do_fetch(J_100, 0);
    do_handoff(0, 1'b1, 1'b0, 16'h0);
    do_fetch(BEQ_W, 0);
    do_handoff(0, 1'b0, 1'b1, 16'h0003);
    check("beq_fwd", bus.imem_addr, 32'h110);
    do_fetch(J_100, 0);
    do_handoff(0, 1'b1, 1'b0, 16'h0);
    do_fetch(BEQ_W, 0);
    do_handoff(0, 1'b0, 1'b0, 16'hFFFE);
    check("beq_not_taken", bus.imem_addr, 32'h104);

    // Stalled handoffs with toggling controls; jump beats branch.
    do_fetch(J_100, 2);
    do_handoff(5, 1'b1, 1'b1, 16'h0003);
    check("jump_wins", bus.imem_addr, 32'h100);
    do_fetch(NOP_W, 0);
    do_handoff(5, 1'b0, 1'b0, 16'h1234);
    check("stall_seq", bus.imem_addr, 32'h104);

    // pc_plus4 wrap at the top of memory.
    do_reset(1'b0);
    do_fetch(BEQ_W, 0);
    do_handoff(0, 1'b0, 1'b1, 16'hFFFE);
    check("wrap_addr", bus.imem_addr, 32'hFFFF_FFFC);
    do_fetch(NOP_W, 0);
    check("wrap_pc_plus4", bus.pc_plus4, 32'h0);
    do_handoff(0, 1'b0, 1'b0, 16'h0);

    // Random traffic.
    for (int i = 0; i < 12; i++) begin
      do_fetch($urandom, $urandom_range(0, 3));
      do_handoff($urandom_range(0, 2), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 16'($urandom));
    end

    // Reset while holding an instruction.
    do_fetch(NOP_W, 0);
    do_reset(1'b1);
    // Reset during a pending fetch, with ack in the same cycle.
    do_fetch(NOP_W, 0);
    do_handoff(0, 1'b0, 1'b0, 16'h0);
    do_reset(1'b1);
    do_fetch(NOP_W, 1);
    do_handoff(0, 1'b0, 1'b0, 16'h0);

    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
